// File: rtl/bus_arbiter_8.sv
// rtl/bus_arbiter_8.sv - round-robin arbiter for 8 requesters sharing one registered bus
module bus_arbiter_8 #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         req,
  input  logic [8*WIDTH-1:0] data_in,
  output logic [7:0]         gnt,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               bus_valid,
  output logic [WIDTH-1:0]   bus_data,
  output logic [2:0]         bus_src
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  logic [0:0]       state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       src_q, src_d;

  logic       xfer;
  logic       rel;
  logic [2:0] arb_ptr;
  logic [2:0] winner;
  logic       win_found;

  always_comb begin
    xfer    = (state_q == ST_GRANT) && req[sel_q];
    rel     = (state_q == ST_GRANT) && (!req[sel_q] || (cnt_q == CNT_LAST));
    // A releasing owner drops to lowest priority in the same cycle's arbitration.
    arb_ptr = rel ? (sel_q + 3'd1) : ptr_q;
  end

  always_comb begin : arb
    logic [2:0] idx;
    winner    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < 8; k++) begin
      idx = arb_ptr + 3'(k);
      if (!win_found && req[idx]) begin
        winner    = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    src_d   = src_q;

    if (xfer) begin
      valid_d = 1'b1;
      data_d  = data_in[sel_q*WIDTH +: WIDTH];
      src_d   = sel_q;
    end

    if ((state_q == ST_IDLE) || rel) begin
      if (rel) begin
        ptr_d = arb_ptr;
      end
      if (win_found) begin
        state_d = ST_GRANT;
        gnt_d   = 8'b1 << winner;
        sel_d   = winner;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign bus_valid = valid_q;
  assign bus_data  = data_q;
  assign bus_src   = src_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_sel_match:  assert property (@(posedge clk) disable iff (rst) busy_q |-> gnt_q[sel_q]);
  a_cnt_range:  assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_LAST);

endmodule
